// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch history table with 2-bit counters and target store.
// Combinational lookup, one-cycle training, mispredict redirect and stats.
module branch_predictor_bht #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic        clear,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = 32 - IW - 2;

  logic [ENTRIES-1:0] valid;
  logic [TW-1:0]      tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  logic [IW-1:0] l_idx;
  logic [TW-1:0] l_tag;
  logic          l_hit;
  logic [IW-1:0] u_idx;
  logic [TW-1:0] u_tag;
  logic          u_hit;
  logic          mis_now;
  logic          unused_lo;

  assign l_idx = if_pc[IW+1:2];
  assign l_tag = if_pc[31:IW+2];
  assign l_hit = valid[l_idx] && (tag_q[l_idx] == l_tag);

  assign pred_taken  = l_hit && ctr_q[l_idx][1];
  assign pred_target = tgt_q[l_idx];

  assign u_idx = upd_pc[IW+1:2];
  assign u_tag = upd_pc[31:IW+2];
  assign u_hit = valid[u_idx] && (tag_q[u_idx] == u_tag);

  assign mis_now   = upd_valid && (upd_taken != upd_pred_taken);
  assign unused_lo = ^if_pc[1:0];

  // Valid bits and counters: reset/clear, train on hit, allocate on taken miss
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
        ctr_q[i] <= 2'b01;
      end
    end else if (clear) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
        ctr_q[i] <= 2'b01;
      end
    end else if (upd_valid) begin
      if (u_hit) begin
        if (upd_taken && ctr_q[u_idx] != 2'b11)
          ctr_q[u_idx] <= ctr_q[u_idx] + 2'd1;
        else if (!upd_taken && ctr_q[u_idx] != 2'b00)
          ctr_q[u_idx] <= ctr_q[u_idx] - 2'd1;
      end else if (upd_taken) begin
        valid[u_idx] <= 1'b1;
        ctr_q[u_idx] <= 2'b10;
      end
    end
  end

  // Tag and target store; unreset, only observable through a set valid bit
  always_ff @(posedge clk) begin
    if (!clear && upd_valid && upd_taken) begin
      tag_q[u_idx] <= u_tag;
      tgt_q[u_idx] <= upd_target;
    end
  end

  // Mispredict pulse, redirect target and saturating statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict  <= 1'b0;
      redirect_pc <= 32'd0;
      branch_cnt  <= 32'd0;
      mispred_cnt <= 32'd0;
    end else begin
      mispredict <= mis_now;
      if (mis_now)
        redirect_pc <= upd_taken ? upd_target : upd_pc + 32'd4;
      if (upd_valid && branch_cnt != 32'hFFFF_FFFF)
        branch_cnt <= branch_cnt + 32'd1;
      if (mis_now && mispred_cnt != 32'hFFFF_FFFF)
        mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Scoreboard bench for branch_predictor_bht: directed rows push expectations,
// a negedge monitor pops and compares lookup and registered outputs.
module tb_branch_predictor_bht;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic        clear;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  typedef struct {
    int          row;
    logic        pt;
    logic        chk_tgt;
    logic [31:0] tgt;
    logic        mis;
    logic [31:0] redir;
    logic [31:0] bcnt;
    logic [31:0] mcnt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   row_no  = 0;

  branch_predictor_bht #(.ENTRIES(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .clear          (clear),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int row,
                     input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL row%0d %s: got %h expected %h", row, nm, got, want);
    end
  endtask

  // Monitor: every negedge with a pending expectation, compare all outputs
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pred_taken", e.row, {31'd0, pred_taken}, {31'd0, e.pt});
      if (e.chk_tgt)
        chk("pred_target", e.row, pred_target, e.tgt);
      chk("mispredict", e.row, {31'd0, mispredict}, {31'd0, e.mis});
      chk("redirect_pc", e.row, redirect_pc, e.redir);
      chk("branch_cnt", e.row, branch_cnt, e.bcnt);
      chk("mispred_cnt", e.row, mispred_cnt, e.mcnt);
    end
  end

  // One cycle of stimulus; expectations are for this cycle's negedge
  task automatic step(
    input logic r, input logic cl,
    input logic uv, input logic [31:0] upc, input logic ut,
    input logic [31:0] utg, input logic upt,
    input logic [31:0] ipc,
    input logic ept, input logic ect, input logic [31:0] etg,
    input logic em, input logic [31:0] er,
    input logic [31:0] eb, input logic [31:0] emc);
    exp_t e;
    @(posedge clk);
    #1;
    rst            = r;
    clear          = cl;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_taken      = ut;
    upd_target     = utg;
    upd_pred_taken = upt;
    if_pc          = ipc;
    e.row     = row_no;
    e.pt      = ept;
    e.chk_tgt = ect;
    e.tgt     = etg;
    e.mis     = em;
    e.redir   = er;
    e.bcnt    = eb;
    e.mcnt    = emc;
    sb.push_back(e);
    row_no++;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0;
    if_pc = '0;
    //   rst cl uv upc     t  utgt    pt ipc     ept ect etgt    em redir   bc  mc
    step(1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h100, 0, 0, 32'h0,   0, 32'h0,   0,  0);
    step(0, 0, 1, 32'h100, 1, 32'h200, 0, 32'h100, 0, 0, 32'h0,   0, 32'h0,   0,  0);
    step(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h100, 1, 1, 32'h200, 1, 32'h200, 1,  1);
    step(0, 0, 1, 32'h100, 0, 32'h0,   1, 32'h100, 1, 1, 32'h200, 0, 32'h200, 1,  1);
    step(0, 0, 1, 32'h100, 0, 32'h0,   0, 32'h100, 0, 0, 32'h0,   1, 32'h104, 2,  2);
    step(0, 0, 1, 32'h100, 0, 32'h0,   0, 32'h100, 0, 0, 32'h0,   0, 32'h104, 3,  2);
    step(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h100, 0, 0, 32'h0,   0, 32'h104, 4,  2);
    step(0, 0, 1, 32'h100, 1, 32'h240, 0, 32'h100, 0, 0, 32'h0,   0, 32'h104, 4,  2);
    step(0, 0, 1, 32'h100, 1, 32'h280, 0, 32'h100, 0, 0, 32'h0,   1, 32'h240, 5,  3);
    step(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h100, 1, 1, 32'h280, 1, 32'h280, 6,  4);
    step(0, 0, 1, 32'h140, 1, 32'h500, 0, 32'h100, 1, 1, 32'h280, 0, 32'h280, 6,  4);
    step(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h100, 0, 0, 32'h0,   1, 32'h500, 7,  5);
    step(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h140, 1, 1, 32'h500, 0, 32'h500, 7,  5);
    step(0, 0, 1, 32'h184, 0, 32'h900, 0, 32'h184, 0, 0, 32'h0,   0, 32'h500, 7,  5);
    step(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h184, 0, 0, 32'h0,   0, 32'h500, 8,  5);
    step(0, 1, 1, 32'h300, 1, 32'h600, 0, 32'h140, 1, 1, 32'h500, 0, 32'h500, 8,  5);
    step(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h300, 0, 0, 32'h0,   1, 32'h600, 9,  6);
    step(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h140, 0, 0, 32'h0,   0, 32'h600, 9,  6);
    step(0, 0, 1, 32'h140, 1, 32'h700, 1, 32'h140, 0, 0, 32'h0,   0, 32'h600, 9,  6);
    step(0, 0, 1, 32'h188, 1, 32'h800, 1, 32'h140, 1, 1, 32'h700, 0, 32'h600, 10, 6);
    step(1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h140, 0, 0, 32'h0,   0, 32'h0,   0,  0);
    step(1, 0, 1, 32'h188, 1, 32'h800, 0, 32'h188, 0, 0, 32'h0,   0, 32'h0,   0,  0);
    step(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h188, 0, 0, 32'h0,   0, 32'h0,   0,  0);
    step(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h140, 0, 0, 32'h0,   0, 32'h0,   0,  0);
    for (int i = 0; i < 20 && sb.size() > 0; i++)
      @(posedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor_bht.md
BRANCH_PREDICTOR_BHT -- requirements
Module: branch_predictor_bht

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of direct-mapped predictor entries (power of two, 4..64).
REQ-002 SHALL derive IW = log2(ENTRIES); index = pc[IW+1:2], tag = pc[31:IW+2].
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 if_pc  input  32  fetch-stage PC for lookup.
REQ-007 pred_taken  output  1  combinational prediction for if_pc.
REQ-008 pred_target  output  32  combinational predicted target for if_pc.
REQ-009 upd_valid  input  1  resolved conditional branch present this cycle.
REQ-010 upd_pc  input  32  PC of the resolved branch.
REQ-011 upd_taken  input  1  resolved outcome, driven from the branch comparator's BrTaken.
REQ-012 upd_target  input  32  computed branch target of the resolved branch.
REQ-013 upd_pred_taken  input  1  prediction originally issued for that branch.
REQ-014 clear  input  1  synchronous invalidate of all entries.
REQ-015 mispredict  output  1  registered one-cycle pulse on a wrong prediction.
REQ-016 redirect_pc  output  32  registered correct next PC, valid while mispredict=1.
REQ-017 branch_cnt  output  32  resolved-branch count.
REQ-018 mispred_cnt  output  32  misprediction count.

Function
REQ-019 SHALL hold per entry: valid (1), tag (32-IW-2), target (32), ctr (2-bit saturating).
REQ-020 lookup: hit = valid[idx] && tag match; pred_taken = hit && ctr[1]; pred_target = target[idx] (don't-care when pred_taken=0).
REQ-021 Lookup SHALL be purely combinational on stored state; an update in cycle N SHALL be visible to lookup from cycle N+1 (same-index lookup in cycle N sees old state).
REQ-022 On upd_valid with hit: ctr SHALL increment if upd_taken (saturate 11), decrement otherwise (saturate 00); target SHALL be overwritten with upd_target only if upd_taken.
REQ-023 On upd_valid with miss and upd_taken=1: SHALL allocate: valid=1, tag written, target=upd_target, ctr=10 (weakly taken), overwriting any previous occupant.
REQ-024 On upd_valid with miss and upd_taken=0: no table change.
REQ-025 mispredict SHALL be registered: next cycle = upd_valid && (upd_taken != upd_pred_taken); 0 otherwise.
REQ-026 redirect_pc SHALL be registered on each mispredict: upd_taken ? upd_target : upd_pc + 32'd4 (mod 2^32); it SHALL hold its value otherwise.
REQ-027 branch_cnt SHALL increment on every upd_valid; mispred_cnt on every mispredict condition; both SHALL saturate at 32'hFFFF_FFFF, no wrap.
REQ-028 clear=1 SHALL zero all valid bits and set every ctr to 01 at the next edge; counters and mispredict logic SHALL be unaffected.
REQ-029 clear and upd_valid in the same cycle: clear wins for the table (no allocate/train); mispredict, redirect_pc and counters SHALL still update.
REQ-030 Update latency SHALL be one cycle; no backpressure; one update per cycle maximum.

Reset
REQ-031 rst=1 SHALL asynchronously set all valid=0, all ctr=01, mispredict=0, redirect_pc=0, branch_cnt=0, mispred_cnt=0; tag/target contents need not be reset.
REQ-032 After reset, pred_taken SHALL be 0 for any if_pc until an allocation occurs.
REQ-033 rst asserted mid-update SHALL discard that update; no partial entry SHALL remain.

Verification
REQ-034 Cold miss allocate: reset; upd_valid, upd_pc=0x100, upd_taken=1, upd_target=0x200, upd_pred_taken=0 -> next cycle mispredict=1, redirect_pc=0x200, counts 1/1; if_pc=0x100 -> pred_taken=1, pred_target=0x200.
REQ-035 Saturation: after REQ-034 three not-taken updates at 0x100 (pred 1,0,0) -> ctr 10->01->00->00, pred_taken=0 after first; mispredict pulses only on first; redirect_pc=0x104.
REQ-036 Aliasing: allocate 0x100, then taken update at 0x140 (ENTRIES=16, same index, different tag) -> lookup 0x100 pred_taken=0, 0x140 pred_taken=1.
REQ-037 Same-cycle hazard: update at 0x100 and if_pc=0x100 same cycle -> pred reflects pre-update state; next cycle reflects new state.
REQ-038 Clear vs update: clear=1 with taken update at 0x300 (pred 0) -> no allocation (lookup 0x300 pred_taken=0), mispredict=1, branch_cnt incremented.
REQ-039 Async reset: assert rst between edges after allocations -> outputs and counters 0 immediately, pred_taken=0 for all PCs.
